// File: rtl/cb_pulse_gen.sv
// cb_pulse_gen: programmable pulse-train generator with burst count, widths and polarity
module cb_pulse_gen #(
    parameter int CNT_W = 16,
    parameter int NUM_W = 8
) (
    input  logic             clk_sys,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] cfg_high,
    input  logic [CNT_W-1:0] cfg_low,
    input  logic [NUM_W-1:0] cfg_num,
    input  logic             cfg_pol,
    output logic             sig_out,
    output logic             busy,
    output logic             done,
    output logic [NUM_W-1:0] pulse_cnt
);
    typedef enum logic [1:0] {IDLE, ACT, INACT} state_t;

    state_t           state;
    logic             pol;
    logic [CNT_W-1:0] high_w;
    logic [CNT_W-1:0] low_w;
    logic [NUM_W-1:0] num;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] high_adj;
    logic [CNT_W-1:0] low_adj;

    // zero-width phases are stretched to one cycle
    always_comb begin
        high_adj = (cfg_high == '0) ? CNT_W'(1) : cfg_high;
        low_adj  = (cfg_low == '0) ? CNT_W'(1) : cfg_low;
    end

    // burst FSM; phase counter counts down to 1, outputs all registered
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            pol       <= 1'b0;
            high_w    <= '0;
            low_w     <= '0;
            num       <= '0;
            cnt       <= '0;
            sig_out   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pulse_cnt <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !abort) begin
                        pol    <= cfg_pol;
                        high_w <= high_adj;
                        low_w  <= low_adj;
                        num    <= cfg_num;
                        if (cfg_num != '0) begin
                            state     <= ACT;
                            sig_out   <= ~cfg_pol;
                            busy      <= 1'b1;
                            pulse_cnt <= NUM_W'(1);
                            cnt       <= high_adj;
                        end else begin
                            sig_out   <= cfg_pol;
                            done      <= 1'b1;
                            pulse_cnt <= '0;
                        end
                    end
                end
                ACT: begin
                    if (abort) begin
                        state   <= IDLE;
                        sig_out <= pol;
                        busy    <= 1'b0;
                    end else if (cnt == CNT_W'(1)) begin
                        state   <= INACT;
                        sig_out <= pol;
                        cnt     <= low_w;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                INACT: begin
                    if (abort) begin
                        state   <= IDLE;
                        sig_out <= pol;
                        busy    <= 1'b0;
                    end else if (cnt != CNT_W'(1)) begin
                        cnt <= cnt - 1'b1;
                    end else if (pulse_cnt < num) begin
                        state     <= ACT;
                        sig_out   <= ~pol;
                        pulse_cnt <= pulse_cnt + 1'b1;
                        cnt       <= high_w;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
